// File: rtl/spi_arbiter_if.sv
// Request/response and SPI-driver handshake bundle for spi_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus driver.
interface spi_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_err;
  logic                 drv_start;
  logic [7:0]           drv_data_in;
  logic                 drv_en;
  logic [7:0]           drv_data_out;

  modport slave (
    input  req, req_data, drv_en, drv_data_out,
    output gnt, rsp_valid, rsp_data, rsp_err, drv_start, drv_data_in
  );

  modport master (
    output req, req_data, drv_en, drv_data_out,
    input  gnt, rsp_valid, rsp_data, rsp_err, drv_start, drv_data_in
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte driver among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a transfer watchdog that reports rsp_err.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst,
  spi_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [7:0]         drv_data_q, drv_data_d;
  logic               drv_start_q, drv_start_d;
  logic [PTR_W-1:0]   rr_win;
  logic [7:0]         req_byte [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    rr_win = ptr_q;
    idx    = 0;
    idx_w  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx   = (int'(ptr_q) + k) % NUM_REQ;
      idx_w = idx[PTR_W-1:0];
      if (bus.req[idx_w]) rr_win = idx_w;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rsp_err_q, rsp_err_d;
  logic            wd_expired;
  assign wd_expired  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    drv_data_d  = drv_data_q;
    drv_start_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d       = rr_win;
          gnt_d       = NUM_REQ'(1) << rr_win;
          drv_data_d  = req_byte[rr_win];
          drv_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!bus.drv_en) state_d = WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
        if (wd_expired) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        // A real completion takes precedence over a watchdog expiring the same cycle.
        if (bus.drv_en) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = bus.drv_data_out;
`ifdef SPI_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wd_expired) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
      drv_data_q  <= 8'h00;
      drv_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      drv_data_q  <= drv_data_d;
      drv_start_q <= drv_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.drv_start   = drv_start_q;
  assign bus.drv_data_in = drv_data_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed plus randomized bench for spi_arbiter with a behavioural driver
// and a round-robin reference model; follows SPI_ARB_TIMEOUT_EN like the RTL.
module tb_spi_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   ptr_m;

  spi_arbiter_if #(.NUM_REQ(4)) bus ();

  spi_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(1023)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner is the first requester found walking forward from the pointer.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[2'((p + k) % 4)]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt), 32'h0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data), 32'h0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'h0);
    check({tag, "_drv_start"}, 32'(bus.drv_start), 32'h0);
    check({tag, "_drv_data"},  32'(bus.drv_data_in), 32'h0);
  endtask

  // One full transfer: driver goes busy at cycle dly, finishes blen cycles later.
  task automatic txn(input logic [3:0] r, input logic [31:0] bytes, input logic [7:0] resp,
                     input int dly, input int blen, input int drop_at);
    int         w;
    logic [3:0] oh;
    logic [7:0] tx;
    int         seen_at;
    w       = rr_pick(r, ptr_m);
    oh      = 4'(1) << w;
    tx      = bytes[8*w +: 8];
    seen_at = -1;
    bus.req      = r;
    bus.req_data = bytes;
    @(negedge clk);
    check("issue_gnt", 32'(bus.gnt), 32'(oh));
    check("issue_drv_start", 32'(bus.drv_start), 32'h1);
    check("issue_drv_data", 32'(bus.drv_data_in), 32'(tx));
    for (int c = 1; c <= dly + blen + 8; c++) begin
      @(negedge clk);
      if (c == 1) check("start_one_cycle", 32'(bus.drv_start), 32'h0);
      if (bus.rsp_valid != 4'b0) begin
        seen_at = c;
        break;
      end
      check("hold_drv_data", 32'(bus.drv_data_in), 32'(tx));
      if (c == dly) bus.drv_en = 1'b0;
      if (c == dly + blen) begin
        bus.drv_en       = 1'b1;
        bus.drv_data_out = resp;
      end
      if (c == drop_at) bus.req[w] = 1'b0;
    end
    check("rsp_cycle", 32'(seen_at), 32'(dly + blen + 1));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    check("rsp_data", 32'(bus.rsp_data), 32'(resp));
    check("rsp_err", 32'(bus.rsp_err), 32'h0);
    check("resp_gnt", 32'(bus.gnt), 32'(oh));
    @(negedge clk);
    check("rsp_pulse_end", 32'(bus.rsp_valid), 32'h0);
    check("gnt_cleared", 32'(bus.gnt), 32'h0);
    check("rsp_data_hold", 32'(bus.rsp_data), 32'(resp));
    $display("txn req=%b winner=%0d tx=%02h rsp=%02h", r, w, tx, bus.rsp_data);
    ptr_m = (w + 1) % 4;
  endtask

  task automatic apply_reset(input string tag);
    bus.req = 4'b0;
    rst     = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    bus.drv_en = 1'b1;
    rst        = 1'b0;
    ptr_m      = 0;
    @(negedge clk);
    check_reset_outputs({tag, "_post"});
  endtask

  initial begin
    int pulses;
    int seen_at;
    n_assert         = 0;
    n_fail           = 0;
    ptr_m            = 0;
    rst              = 1'b1;
    bus.req          = 4'b0;
    bus.req_data     = '0;
    bus.drv_en       = 1'b1;
    bus.drv_data_out = 8'h00;
    @(negedge clk);
    apply_reset("reset");

    // Single request with a loopback driver.
    txn(4'b0010, 32'h0000_A500, 8'hA5, 2, 4, -1);
    bus.req = 4'b0;
    @(negedge clk);

    // All requesting after reset: expect 0,1,2,3,0.
    apply_reset("reset2");
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, $urandom, 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 5), -1);
    end
    bus.req = 4'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      txn(4'($urandom_range(1, 15)), $urandom, 8'($urandom),
          $urandom_range(1, 4), $urandom_range(1, 6), -1);
    end

    // Requester 2 withdraws 10 cycles after its grant.
    txn(4'b0100, 32'h0033_0000, 8'h5C, 3, 15, 10);
    bus.req = 4'b0;
    @(negedge clk);

    // Reset while WAIT_DONE.
    bus.req = 4'b1000;
    @(negedge clk);
    check("mid_issue_gnt", 32'(bus.gnt), 32'h8);
    bus.req    = 4'b0;
    bus.drv_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    bus.drv_en = 1'b1;
    rst        = 1'b0;
    ptr_m      = 0;
    pulses     = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'b0) pulses++;
    end
    check("mid_rst_no_rsp", 32'(pulses), 32'h0);
    txn(4'b1111, $urandom, 8'($urandom), 2, 3, -1);
    bus.req = 4'b0;
    @(negedge clk);

    // Stuck driver: drv_en never drops.
    bus.req = 4'b0001;
    @(negedge clk);
    check("stuck_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0;
    pulses  = 0;
    seen_at = -1;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'b0) begin
        seen_at = c;
        break;
      end
    end
    check("timeout_cycle", 32'(seen_at), 32'd1024);
    check("timeout_valid", 32'(bus.rsp_valid), 32'h1);
    check("timeout_err", 32'(bus.rsp_err), 32'h1);
    check("timeout_data", 32'(bus.rsp_data), 32'h0);
    @(negedge clk);
    check("timeout_err_hold", 32'(bus.rsp_err), 32'h1);
`else
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'b0) pulses++;
    end
    check("stuck_no_rsp", 32'(pulses), 32'h0);
    check("stuck_gnt_held", 32'(bus.gnt), 32'h1);
    check("stuck_err_zero", 32'(bus.rsp_err), 32'h0);
`endif
    apply_reset("final_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the transfer watchdog limit in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req, input, NUM_REQ bits: per-requester transfer request, level-sensitive.
REQ-006 SHALL have port req_data, input, NUM_REQ*8 bits: TX byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port gnt, output, NUM_REQ bits: one-hot grant, or all-zero.
REQ-008 SHALL have port rsp_valid, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rsp_data, output, 8 bits: received byte, valid while any rsp_valid bit is high.
REQ-010 SHALL have port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-011 SHALL have port drv_start, output, 1 bit: start pulse to the SPI driver.
REQ-012 SHALL have port drv_data_in, output, 8 bits: TX byte to the SPI driver.
REQ-013 SHALL have port drv_en, input, 1 bit: the driver's active-low slave enable, used as its busy indicator.
REQ-014 SHALL have port drv_data_out, input, 8 bits: the driver's received byte.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESP.
REQ-016 SHALL, in IDLE with req!=0, select the winner round-robin starting at pointer ptr, latch its req_data into drv_data_in, set the gnt bit and go to ISSUE; with req==0 it SHALL stay in IDLE.
REQ-017 SHALL hold drv_start=1 for exactly the one ISSUE cycle, then go to WAIT_BUSY; drv_start is registered, so request-to-start latency is 1 cycle.
REQ-018 SHALL, in WAIT_BUSY, stay until drv_en==0 is sampled, then go to WAIT_DONE.
REQ-019 SHALL, in WAIT_DONE, on sampling drv_en==1, capture drv_data_out into rsp_data and go to RESP.
REQ-020 SHALL, in RESP, pulse rsp_valid[winner] for 1 cycle, clear gnt, set ptr to (winner+1) mod NUM_REQ and return to IDLE.
REQ-021 SHALL hold gnt from ISSUE through RESP inclusive, and SHALL keep drv_data_in stable for the whole transaction.
REQ-022 SHALL ignore req changes while not in IDLE; a requester deasserting req mid-transfer SHALL still receive rsp_valid.
REQ-023 SHALL re-arbitrate a still-asserted req in the IDLE cycle after RESP; a back-to-back transfer therefore has 1 IDLE gap cycle.
REQ-024 SHALL grant requester 0 first after reset when all requests are equal, and SHALL wrap the pointer from NUM_REQ-1 to 0.
REQ-025 SHALL hold rsp_data and rsp_err until the next RESP.

Reset
REQ-026 SHALL, on rst, force state=IDLE, ptr=0, gnt=0, rsp_valid=0, rsp_data=0x00, rsp_err=0, drv_start=0, drv_data_in=0x00 and watchdog counter=0.
REQ-027 SHALL abandon a transfer in progress when rst is asserted, with no rsp_valid issued.

Configuration
REQ-028 SHALL, with macro SPI_ARB_TIMEOUT_EN defined, clear the watchdog counter in ISSUE and increment it each WAIT_BUSY/WAIT_DONE cycle; when it reaches TIMEOUT_CYCLES the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0x00.
REQ-029 SHALL, without SPI_ARB_TIMEOUT_EN, have no watchdog, wait indefinitely for drv_en, and tie rsp_err to 0.

Verification
REQ-030 SHALL cover single request: req=4'b0010 with byte1=0xA5 against a driver looping MOSI back to MISO -> drv_start one cycle after req, gnt=4'b0010, then rsp_valid=4'b0010 with rsp_data=0xA5 and rsp_err=0.
REQ-031 SHALL cover all requesting: req=4'b1111 held -> grant order 0,1,2,3,0, with exactly one rsp_valid per transfer.
REQ-032 SHALL cover request withdrawal: req[2] dropped 10 cycles after its grant -> transfer completes and rsp_valid[2] still pulses.
REQ-033 SHALL cover a stuck driver with SPI_ARB_TIMEOUT_EN defined: drv_en held 1 -> RESP after 1023 wait cycles with rsp_err=1 and rsp_data=0x00; without the macro, no rsp_valid after 5000 cycles.
REQ-034 SHALL cover mid-transfer reset: rst pulsed while in WAIT_DONE -> all outputs return to reset values, no rsp_valid, and the next grant goes to requester 0.
